// File: rtl/button_repeat_conditioner_if.sv
// Button bus shared by the input pins, the conditioner and the VGA clock core.
// The conditioner takes the slave side; whoever drives the raw pins takes the master side.
interface button_repeat_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic             tick_out;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  tick_out
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output tick_out
  );
endinterface

// File: rtl/button_repeat_conditioner.sv
// Synchronises, debounces and hold-to-repeats the clock setting buttons so the
// core sees one increment per press, or a paced increment stream while held.
module button_repeat_conditioner #(
  parameter int               N_BTN               = 5,
  parameter int               TICK_DIV            = 25175,
  parameter int               DEBOUNCE_TICKS      = 20,
  parameter int               REPEAT_DELAY_TICKS  = 500,
  parameter int               REPEAT_PERIOD_TICKS = 100,
  parameter logic [N_BTN-1:0] REPEAT_MASK         = 5'b00111
) (
  input logic                        video_clk,
  input logic                        reset_n,
  button_repeat_conditioner_if.slave bus
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                        REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] RD_LAST    = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] RP_LAST    = RW'(REPEAT_PERIOD_TICKS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_pulse;

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [DW-1:0] r_dbCnt;
    logic          r_level;
    logic [1:0]    r_state;
    logic [RW-1:0] r_rcnt;
    logic          r_pulse;
    logic          w_disagree;
    logic          w_accept;
    logic          w_rise;
    logic          w_fall;

    assign w_disagree = (r_sync2[g] != r_level);
    assign w_accept   = w_disagree && w_tick && (r_dbCnt == DB_LAST);
    assign w_rise     = w_accept && r_sync2[g];
    assign w_fall     = w_accept && !r_sync2[g];

    always_ff @(posedge video_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_dbCnt <= '0;
        r_level <= 1'b0;
      end else if (!w_disagree) begin
        r_dbCnt <= '0;
      end else if (w_tick) begin
        if (r_dbCnt == DB_LAST) begin
          r_level <= r_sync2[g];
          r_dbCnt <= '0;
        end else begin
          r_dbCnt <= r_dbCnt + 1'b1;
        end
      end
    end

    // The FSM reacts to the same edge that updates r_level, so the press
    // pulse lines up with the first high level and a release beats a repeat.
    always_ff @(posedge video_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= S_IDLE;
        r_rcnt  <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (w_fall) begin
          r_state <= S_IDLE;
          r_rcnt  <= '0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_rise) begin
                r_pulse <= 1'b1;
                r_state <= S_DELAY;
                r_rcnt  <= '0;
              end
            end
            S_DELAY: begin
              if (w_tick) begin
                if (r_rcnt == RD_LAST) begin
                  if (REPEAT_MASK[g]) begin
                    r_pulse <= 1'b1;
                    r_state <= S_REPEAT;
                    r_rcnt  <= '0;
                  end
                end else begin
                  r_rcnt <= r_rcnt + 1'b1;
                end
              end
            end
            S_REPEAT: begin
              if (w_tick) begin
                if (r_rcnt == RP_LAST) begin
                  r_pulse <= 1'b1;
                  r_rcnt  <= '0;
                end else begin
                  r_rcnt <= r_rcnt + 1'b1;
                end
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_rcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign w_level[g] = r_level;
    assign w_pulse[g] = r_pulse;
  end

  assign bus.btn_level = w_level;
  assign bus.btn_pulse = w_pulse;
  assign bus.tick_out  = w_tick;

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// Directed and random button stimulus checked cycle by cycle against a
// tick-counting reference model of the conditioner.
module tb_button_repeat_conditioner;

  localparam int         N_BTN = 5;
  localparam int         TD    = 4;
  localparam int         DB    = 3;
  localparam int         RD    = 8;
  localparam int         RP    = 2;
  localparam logic [4:0] MASK  = 5'b00111;

  logic video_clk = 1'b0;
  logic reset_n   = 1'b0;

  button_repeat_conditioner_if #(.N_BTN(N_BTN)) bus ();

  button_repeat_conditioner #(
    .N_BTN               (N_BTN),
    .TICK_DIV            (TD),
    .DEBOUNCE_TICKS      (DB),
    .REPEAT_DELAY_TICKS  (RD),
    .REPEAT_PERIOD_TICKS (RP),
    .REPEAT_MASK         (MASK)
  ) dut (
    .video_clk (video_clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 video_clk = ~video_clk;

  int         compared   = 0;
  int         mismatched = 0;

  // Model: cycles since reset, synchroniser taps, disagreeing-tick counts and
  // ticks elapsed since each press.
  int         mCycle;
  logic [4:0] mSync1, mSync2, mLevel, mPulse;
  int         mDis   [5];
  int         mTicks [5];
  logic [4:0] maskVar;

  task automatic modelReset();
    mCycle = 0;
    mSync1 = '0;
    mSync2 = '0;
    mLevel = '0;
    mPulse = '0;
    for (int i = 0; i < 5; i++) begin
      mDis[i]   = 0;
      mTicks[i] = 0;
    end
  endtask

  task automatic modelEdge(input logic [4:0] raw);
    bit   tk;
    logic newLevel;
    tk = ((mCycle % TD) == TD - 1);
    for (int i = 0; i < 5; i++) begin
      mPulse[i] = 1'b0;
      newLevel  = mLevel[i];
      if (mSync2[i] == mLevel[i]) begin
        mDis[i] = 0;
      end else if (tk) begin
        if (mDis[i] == DB - 1) begin
          newLevel = mSync2[i];
          mDis[i]  = 0;
        end else begin
          mDis[i]++;
        end
      end
      if (!mLevel[i] && newLevel) begin
        mPulse[i] = 1'b1;
        mTicks[i] = 0;
      end else if (mLevel[i] && newLevel && tk) begin
        mTicks[i]++;
        if (maskVar[i] && (mTicks[i] == RD || (mTicks[i] > RD && ((mTicks[i] - RD) % RP) == 0)))
          mPulse[i] = 1'b1;
      end
      mLevel[i] = newLevel;
    end
    mSync2 = mSync1;
    mSync1 = raw;
    mCycle++;
  endtask

  task automatic checkOutput(input string tag);
    logic expTick;
    expTick = ((mCycle % TD) == TD - 1);
    compared += 3;
    assert (bus.btn_level === mLevel) else begin
      mismatched++;
      $error("[TB] FAIL %s level: observed %b expected %b", tag, bus.btn_level, mLevel);
    end
    assert (bus.btn_pulse === mPulse) else begin
      mismatched++;
      $error("[TB] FAIL %s pulse: observed %b expected %b", tag, bus.btn_pulse, mPulse);
    end
    assert (bus.tick_out === expTick) else begin
      mismatched++;
      $error("[TB] FAIL %s tick: observed %b expected %b", tag, bus.tick_out, expTick);
    end
  endtask

  task automatic checkVal(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
    compared++;
    assert ((observed >= lo && observed <= hi) === 1'b1) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] raw, input string tag);
    bus.btn_raw = raw;
    @(posedge video_clk);
    modelEdge(raw);
    #1;
    checkOutput(tag);
  endtask

  task automatic holdReset(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(posedge video_clk);
      modelReset();
      #1;
      checkOutput(tag);
    end
  endtask

  task automatic releaseAll(input string tag);
    int c;
    c = 0;
    do begin
      applyStimulus(5'b00000, tag);
      c++;
    end while (bus.btn_level != 5'b00000 && c < 60);
    checkVal({tag, "Settled"}, int'(bus.btn_level), 0);
    for (int k = 0; k < 4; k++) applyStimulus(5'b00000, tag);
  endtask

  initial begin
    int         lat, firstTick, ticks, pulses, badOffs, off;
    logic [4:0] raw;

    maskVar     = MASK;
    bus.btn_raw = 5'h1F;
    modelReset();
    #1;
    checkOutput("resetStart");
    holdReset(5, "resetHold");
    reset_n = 1'b1;

    firstTick = -1;
    ticks     = 0;
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(5'b00000, "tickPhase");
      if (bus.tick_out) begin
        ticks++;
        if (firstTick < 0) firstTick = c;
      end
    end
    checkVal("firstTickCycle", firstTick, 3);
    checkVal("ticksIn12", ticks, 3);

    lat = 0;
    do begin
      applyStimulus(5'b00001, "press0");
      lat++;
    end while (!bus.btn_level[0] && lat < 40);
    checkRange("press0Latency", lat, 11, 14);
    checkVal("press0Pulse", int'(bus.btn_pulse[0]), 1);
    applyStimulus(5'b00001, "press0After");
    checkVal("press0PulseOneCycle", int'(bus.btn_pulse[0]), 0);
    lat    = 0;
    pulses = 0;
    do begin
      applyStimulus(5'b00000, "release0");
      lat++;
      if (bus.btn_pulse[0]) pulses++;
    end while (bus.btn_level[0] && lat < 40);
    checkRange("release0Latency", lat, 11, 14);
    checkVal("release0Pulses", pulses, 0);
    releaseAll("settle0");

    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(((c / 3) % 2 == 0) ? 5'b00010 : 5'b00000, "bounce1");
      if (bus.btn_pulse[1]) pulses++;
    end
    checkVal("bouncePulses", pulses, 0);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(5'b00010, "settle1");
      if (bus.btn_pulse[1]) pulses++;
    end
    checkVal("settledPressPulses", pulses, 1);
    releaseAll("release1");

    lat = 0;
    do begin
      applyStimulus(5'b00100, "press2");
      lat++;
    end while (!bus.btn_pulse[2] && lat < 40);
    checkVal("press2Seen", int'(bus.btn_pulse[2]), 1);
    pulses  = 0;
    badOffs = 0;
    for (int c = 1; c <= 100; c++) begin
      applyStimulus(5'b00100, "hold2");
      if (bus.btn_pulse[2]) begin
        pulses++;
        if (c < 32 || ((c - 32) % 8) != 0) badOffs++;
      end
    end
    checkVal("hold2Repeats", pulses, 9);
    checkVal("hold2BadOffsets", badOffs, 0);
    lat = 0;
    do begin
      applyStimulus(5'b00000, "release2");
      lat++;
    end while (bus.btn_level[2] && lat < 40);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(5'b00000, "after2");
      if (bus.btn_pulse[2]) pulses++;
    end
    checkVal("after2Pulses", pulses, 0);

    pulses = 0;
    for (int c = 0; c < 115; c++) begin
      applyStimulus(5'b10000, "hold4");
      if (bus.btn_pulse[4]) pulses++;
    end
    checkVal("hold4Pulses", pulses, 1);
    releaseAll("release4");

    badOffs = 0;
    pulses  = 0;
    for (int c = 0; c < 80; c++) begin
      applyStimulus(5'b00011, "hold01");
      if (bus.btn_pulse[0] !== bus.btn_pulse[1]) badOffs++;
      if (bus.btn_pulse[0]) pulses++;
    end
    checkVal("hold01Skew", badOffs, 0);
    checkRange("hold01Pulses", pulses, 5, 6);
    releaseAll("release01");

    lat = 0;
    do begin
      applyStimulus(5'b00001, "pressR");
      lat++;
    end while (!bus.btn_pulse[0] && lat < 40);
    for (int c = 0; c < 20; c++) applyStimulus(5'b00001, "holdR");
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("resetMidHold");
    checkVal("resetMidLevel", int'(bus.btn_level), 0);
    holdReset(3, "resetMidHoldCycles");
    reset_n = 1'b1;
    lat = 0;
    do begin
      applyStimulus(5'b00001, "repressR");
      lat++;
    end while (!bus.btn_pulse[0] && lat < 40);
    checkRange("repressLatency", lat, 11, 14);
    off = 0;
    do begin
      applyStimulus(5'b00001, "repeatR");
      off++;
    end while (!bus.btn_pulse[0] && off < 60);
    checkVal("repeatRFirstOffset", off, 32);
    releaseAll("releaseR");

    raw = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 29) == 0) raw[i] = ~raw[i];
      applyStimulus(raw, "random");
    end
    releaseAll("releaseRandom");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
